// File: rtl/data_mem_master_if.sv
// Request, write-data, response and RAM-port signals of the data-memory initiator.
// The master modport is the initiator; the slave modport is its environment (requester plus RAM).
interface data_mem_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [LEN_W-1:0]  ReqLen;
  logic              WDataValid;
  logic              WDataReady;
  logic [DATA_W-1:0] WData;
  logic              RspValid;
  logic              RspReady;
  logic [DATA_W-1:0] RspData;
  logic              RspLast;
  logic              Busy;
  logic              ReqErr;
  logic [ADDR_W-1:0] MemAddress;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqLen, WDataValid, WData, RspReady, MemRData,
    output ReqReady, WDataReady, RspValid, RspData, RspLast, Busy, ReqErr,
           MemAddress, MemRead, MemWrite, MemWData
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqLen, WDataValid, WData, RspReady, MemRData,
    input  ReqReady, WDataReady, RspValid, RspData, RspLast, Busy, ReqErr,
           MemAddress, MemRead, MemWrite, MemWData
  );
endinterface

// File: rtl/data_mem_master.sv
// Burst initiator for the single-port data RAM: word/burst requests, write-data and read-response channels.
// Optional MEM_BOUND_CHECK_EN: bursts crossing the top of the RAM are rejected with a ReqErr pulse.
module data_mem_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256,
  parameter int LEN_W     = 8
) (
  input logic            CLK,
  input logic            RST_N,
  data_mem_master_if.master bus
);
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [LEN_W:0] ONE_BEAT = 1;

  typedef enum logic [1:0] {IDLE, RD, RD_DRAIN, WR} state_e;

  state_e            state;
  state_e            stateNext;
  logic [MEM_AW-1:0] curAddr;
  logic [LEN_W:0]    remain;
  logic              rspValid;
  logic              rspLast;
  logic [DATA_W-1:0] rspData;
  logic [MEM_AW-1:0] reqAddrMod;
  logic              reqFire;
  logic              rdIssue;
  logic              wrBeat;
  logic              lastBeat;
  logic              boundErr;

  assign reqAddrMod = bus.ReqAddr[MEM_AW-1:0];
  assign reqFire    = (state == IDLE) && bus.ReqValid;
  // A new read may be launched only when the response register is empty or draining this cycle.
  assign rdIssue    = (state == RD) && (!rspValid || bus.RspReady);
  assign wrBeat     = (state == WR) && bus.WDataValid;
  assign lastBeat   = (remain == ONE_BEAT);

`ifdef MEM_BOUND_CHECK_EN
  logic reqErr;

  assign boundErr = (int'(reqAddrMod) + int'(bus.ReqLen) + 1) > MEM_DEPTH;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) reqErr <= 1'b0;
    else        reqErr <= reqFire && boundErr;
  end

  assign bus.ReqErr = reqErr;
`else
  assign boundErr   = 1'b0;
  assign bus.ReqErr = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (reqFire && !boundErr) stateNext = bus.ReqWrite ? WR : RD;
      RD:       if (rdIssue && lastBeat) stateNext = RD_DRAIN;
      RD_DRAIN: if (rspValid && bus.RspReady) stateNext = IDLE;
      WR:       if (wrBeat && lastBeat) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    bus.ReqReady   = 1'b0;
    bus.WDataReady = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.MemAddress = '0;
    bus.MemWData   = '0;
    unique case (state)
      IDLE: bus.ReqReady = 1'b1;
      RD: if (rdIssue) begin
        bus.MemRead    = 1'b1;
        bus.MemAddress = ADDR_W'(curAddr);
      end
      WR: begin
        bus.WDataReady = 1'b1;
        if (bus.WDataValid) begin
          bus.MemWrite   = 1'b1;
          bus.MemAddress = ADDR_W'(curAddr);
          bus.MemWData   = bus.WData;
        end
      end
      default: ;
    endcase
  end

  // Address wraps for free: curAddr is exactly log2(MEM_DEPTH) bits wide.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      curAddr <= '0;
      remain  <= '0;
    end else if (reqFire) begin
      curAddr <= reqAddrMod;
      remain  <= {1'b0, bus.ReqLen} + 1'b1;
    end else if (rdIssue || wrBeat) begin
      curAddr <= curAddr + 1'b1;
      remain  <= remain - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rspValid <= 1'b0;
      rspLast  <= 1'b0;
      rspData  <= '0;
    end else if (rdIssue) begin
      rspData  <= bus.MemRData;
      rspValid <= 1'b1;
      rspLast  <= lastBeat;
    end else if (rspValid && bus.RspReady) begin
      rspValid <= 1'b0;
      rspLast  <= 1'b0;
    end
  end

  assign bus.RspValid = rspValid;
  assign bus.RspData  = rspData;
  assign bus.RspLast  = rspLast;
  assign bus.Busy     = (state != IDLE);
endmodule

// File: tb/tb_data_mem_master.sv
// Randomised bench for data_mem_master: transaction-level model (queues of expected beats) plus directed literal checks.
module tb_data_mem_master;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 256;
  localparam int LEN_W     = 8;
  localparam int MEM_AW    = 8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  data_mem_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  data_mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  // RAM the DUT talks to: combinational read, write at the clock edge.
  logic [DATA_W-1:0] ram [MEM_DEPTH];
  always @(posedge CLK) if (bus.MemWrite) ram[bus.MemAddress[MEM_AW-1:0]] <= bus.MemWData;
  assign bus.MemRData = ram[bus.MemAddress[MEM_AW-1:0]];

  int passCnt = 0;
  int checkCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit crosses(input int unsigned addr, input int unsigned len);
    bit c;
    c = ((addr % MEM_DEPTH) + len + 1) > MEM_DEPTH;
`ifndef MEM_BOUND_CHECK_EN
    c = 1'b0;
`endif
    return c;
  endfunction

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] refMem [MEM_DEPTH];
  int unsigned       wrAddrQ[$];
  int unsigned       rdAddrQ[$];
  logic [DATA_W-1:0] rdDataQ[$];
  bit                rdLastQ[$];
  bit                outstanding;
  bit                errNext;
  logic [DATA_W-1:0] rxData[$];
  bit                rxLast[$];

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int hsCycle, firstWrCycle, firstRspCycle, lastWrBeatCycle;
  int unsigned firstWrAddr;
  bit awaitWr, awaitRsp;
  int errPulses = 0;
  int memWriteCycles = 0;

  bit prevStall;
  logic [DATA_W-1:0] prevData;
  logic prevLast;
  bit idleExp, issueExp, wrBeatExp, stallNow;
  int unsigned ma;
  logic [DATA_W-1:0] md;
  bit ml;

  always @(negedge CLK) begin
    if (!RST_N) begin
      check("rst_ReqReady", bus.ReqReady, 1);
      check("rst_flags", {bus.RspValid, bus.RspLast, bus.Busy, bus.ReqErr,
                          bus.MemRead, bus.MemWrite, bus.WDataReady}, 0);
      check("rst_RspData", bus.RspData, 0);
      check("rst_MemAddress", bus.MemAddress, 0);
      check("rst_MemWData", bus.MemWData, 0);
      wrAddrQ.delete(); rdAddrQ.delete(); rdDataQ.delete(); rdLastQ.delete();
      outstanding = 0; errNext = 0; prevStall = 0; awaitWr = 0; awaitRsp = 0;
    end else begin
      idleExp = (wrAddrQ.size() == 0) && (rdAddrQ.size() == 0) && !outstanding;
      check("ReqReady", bus.ReqReady, idleExp);
      check("Busy", bus.Busy, !idleExp);
      check("WDataReady", bus.WDataReady, wrAddrQ.size() != 0);
      check("ReqErr", bus.ReqErr, errNext);
      check("RspValid", bus.RspValid, outstanding);
      if (prevStall) begin
        check("hold_RspData", bus.RspData, prevData);
        check("hold_RspLast", bus.RspLast, prevLast);
      end
      if (bus.ReqErr) errPulses++;
      if (bus.MemWrite) memWriteCycles++;

      issueExp  = (rdAddrQ.size() != 0) && (!outstanding || bus.RspReady);
      wrBeatExp = (wrAddrQ.size() != 0) && bus.WDataValid;
      check("MemRead", bus.MemRead, issueExp);
      check("MemWrite", bus.MemWrite, wrBeatExp);
      if (wrBeatExp) begin
        ma = wrAddrQ.pop_front();
        check("wr_MemAddress", bus.MemAddress, ma);
        check("wr_MemWData", bus.MemWData, bus.WData);
        refMem[ma] = bus.WData;
        if (awaitWr) begin
          firstWrCycle = cyc; firstWrAddr = bus.MemAddress; awaitWr = 0;
        end
        lastWrBeatCycle = cyc;
      end else if (issueExp) begin
        ma = rdAddrQ.pop_front();
        check("rd_MemAddress", bus.MemAddress, ma);
        check("rd_MemWData", bus.MemWData, 0);
      end else begin
        check("idle_mem_bus", {bus.MemAddress, bus.MemWData}, 0);
      end

      if (outstanding && awaitRsp) begin
        firstRspCycle = cyc; awaitRsp = 0;
      end
      if (outstanding && bus.RspReady) begin
        md = rdDataQ.pop_front();
        ml = rdLastQ.pop_front();
        check("RspData", bus.RspData, md);
        check("RspLast", bus.RspLast, ml);
        rxData.push_back(bus.RspData);
        rxLast.push_back(bus.RspLast);
      end
      stallNow = outstanding && !bus.RspReady;
      if (issueExp) outstanding = 1;
      else if (outstanding && bus.RspReady) outstanding = 0;
      prevStall = stallNow;
      prevData  = bus.RspData;
      prevLast  = bus.RspLast;

      errNext = 0;
      if (bus.ReqValid && idleExp) begin
        hsCycle = cyc;
        if (crosses(bus.ReqAddr, bus.ReqLen)) begin
          errNext = 1;
        end else if (bus.ReqWrite) begin
          for (int k = 0; k <= int'(bus.ReqLen); k++)
            wrAddrQ.push_back((bus.ReqAddr + k) % MEM_DEPTH);
          awaitWr = 1;
        end else begin
          for (int k = 0; k <= int'(bus.ReqLen); k++) begin
            ma = (bus.ReqAddr + k) % MEM_DEPTH;
            rdAddrQ.push_back(ma);
            rdDataQ.push_back(refMem[ma]);
            rdLastQ.push_back(k == int'(bus.ReqLen));
          end
          awaitRsp = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] wrData[$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sendReq(input bit wr, input int unsigned addr, input int unsigned len, output bit ok);
    bus.ReqValid = 1'b1;
    bus.ReqWrite = wr;
    bus.ReqAddr  = ADDR_W'(addr);
    bus.ReqLen   = LEN_W'(len);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge CLK);
      ok = bus.ReqReady;
      step();
    end
    bus.ReqValid = 1'b0;
    bus.ReqAddr  = ADDR_W'($urandom);
    if (!ok) check("req_timeout", 0, 1);
  endtask

  task automatic doWrite(input int unsigned addr, input int unsigned len, input int unsigned gapPct, input bit early);
    bit ok, acc, v;
    int k;
    if (early) begin
      bus.WDataValid = 1'b1;
      bus.WData      = wrData[0];
    end
    sendReq(1'b1, addr, len, ok);
    if (ok && !crosses(addr, len)) begin
      k = 0;
      for (int t = 0; t < 4000 && k <= int'(len); t++) begin
        v = (early && k == 0) || ($urandom_range(99) >= gapPct);
        bus.WDataValid = v;
        bus.WData      = v ? wrData[k] : DATA_W'($urandom);
        @(negedge CLK);
        acc = bus.WDataValid && bus.WDataReady;
        step();
        if (acc) k++;
      end
      if (k <= int'(len)) check("wr_timeout", k, len + 1);
    end
    bus.WDataValid = 1'b0;
  endtask

  task automatic doRead(input int unsigned addr, input int unsigned len, input int mode);
    bit ok, done;
    bus.RspReady = 1'b0;
    sendReq(1'b0, addr, len, ok);
    if (ok && !crosses(addr, len)) begin
      done = 0;
      for (int t = 0; t < 5000 && !done; t++) begin
        case (mode)
          0:       bus.RspReady = 1'b1;
          1:       bus.RspReady = (t % 4 == 0) || (t % 4 == 3);
          default: bus.RspReady = 1'($urandom);
        endcase
        @(negedge CLK);
        done = !bus.Busy;
        step();
      end
      if (!done) check("rd_timeout", 0, 1);
    end
    bus.RspReady = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int errP0, mw0, mism;
    bit ok;
    logic [DATA_W-1:0] x;

    for (int i = 0; i < MEM_DEPTH; i++) begin
      ram[i] = '0;
      refMem[i] = '0;
    end
    bus.ReqValid = 0; bus.ReqWrite = 0; bus.ReqAddr = '0; bus.ReqLen = '0;
    bus.WDataValid = 0; bus.WData = '0; bus.RspReady = 0;

    repeat (3) @(posedge CLK);
    #2;
    check("reset_ReqReady_lit", bus.ReqReady, 1);
    check("reset_RspValid_lit", bus.RspValid, 0);
    RST_N = 1'b1;
    step();

    // Single write then read of one word.
    wrData = '{16'h1234};
    doWrite(32'h05, 0, 0, 1'b1);
    check("t1_wr_latency", firstWrCycle - hsCycle, 1);
    check("t1_wr_addr", firstWrAddr, 32'h05);
    check("t1_ram", ram[5], 16'h1234);
    rxData.delete(); rxLast.delete();
    doRead(32'h05, 0, 0);
    check("t1_rd_latency", firstRspCycle - hsCycle, 2);
    check("t1_rd_count", rxData.size(), 1);
    if (rxData.size() == 1) begin
      check("t1_rd_data", rxData[0], 16'h1234);
      check("t1_rd_last", rxLast[0], 1);
    end

    // Read burst under 1,0,0,1 backpressure.
    wrData = '{16'hA0, 16'hA1, 16'hA2, 16'hA3};
    doWrite(32'h10, 3, 30, 1'b0);
    rxData.delete(); rxLast.delete();
    doRead(32'h10, 3, 1);
    check("t2_rd_count", rxData.size(), 4);
    if (rxData.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("t2_rd_data", rxData[i], 32'hA0 + i);
        check("t2_rd_last", rxLast[i], i == 3);
      end

    // Write burst across the top of the RAM.
    wrData = '{16'd1, 16'd2, 16'd3, 16'd4};
    errP0 = errPulses;
    mw0   = memWriteCycles;
    doWrite(32'hFE, 3, 40, 1'b0);
    repeat (2) step();
`ifdef MEM_BOUND_CHECK_EN
    check("t3_err_pulses", errPulses - errP0, 1);
    check("t3_no_writes", memWriteCycles - mw0, 0);
`else
    check("t3_err_pulses", errPulses - errP0, 0);
    check("t3_write_count", memWriteCycles - mw0, 4);
    check("t3_ram_fe", ram[8'hFE], 1);
    check("t3_ram_ff", ram[8'hFF], 2);
    check("t3_ram_00", ram[8'h00], 3);
    check("t3_ram_01", ram[8'h01], 4);
`endif

    // Reset during beat 2 of an 8-beat read.
    wrData.delete();
    for (int i = 0; i < 8; i++) wrData.push_back(DATA_W'($urandom));
    doWrite(32'h40, 7, 20, 1'b0);
    bus.RspReady = 1'b1;
    sendReq(1'b0, 32'h40, 7, ok);
    step();
    #2;
    RST_N = 1'b0;
    #1;
    check("t4_async_ReqReady", bus.ReqReady, 1);
    check("t4_async_flags", {bus.RspValid, bus.RspLast, bus.Busy, bus.MemRead,
                             bus.MemWrite, bus.WDataReady}, 0);
    check("t4_async_MemAddress", bus.MemAddress, 0);
    bus.RspReady = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    step();
    rxData.delete(); rxLast.delete();
    doRead(32'h40, 1, 0);
    check("t4_after_count", rxData.size(), 2);
    if (rxData.size() == 2) check("t4_after_data", rxData[1], wrData[1]);

    // Write immediately followed by a read of the same word.
    x = 16'h5A3C;
    wrData = '{x};
    doWrite(32'h20, 0, 0, 1'b1);
    rxData.delete(); rxLast.delete();
    doRead(32'h20, 0, 0);
    check("t5_b2b_gap", hsCycle - lastWrBeatCycle, 1);
    check("t5_b2b_count", rxData.size(), 1);
    if (rxData.size() == 1) check("t5_b2b_data", rxData[0], 16'h5A3C);

    // Maximum-length read burst.
    rxData.delete(); rxLast.delete();
    doRead(32'h0, 255, 0);
    check("t6_max_count", rxData.size(), 256);

    // Random traffic; upper address bits are random and must be dropped.
    for (int n = 0; n < 40; n++) begin
      int unsigned a, l;
      a = $urandom_range(0, 65535);
      l = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) begin
        wrData.delete();
        for (int i = 0; i <= int'(l); i++) wrData.push_back(DATA_W'($urandom));
        doWrite(a, l, $urandom_range(0, 50), 1'($urandom));
      end else begin
        doRead(a, l, $urandom_range(0, 2));
      end
    end
    repeat (3) step();

    mism = 0;
    for (int i = 0; i < MEM_DEPTH; i++) if (ram[i] !== refMem[i]) mism++;
    check("final_ram_image", mism, 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- Initiator side of the data-memory interface: drives the address, read strobe, write strobe and write data of the single-port data RAM, and captures its read data.
- Accepts single-word or burst requests from the datapath/DMA over a valid/ready handshake. Burst addresses auto-increment.
- Returns read data over a registered valid/ready response channel. Accepts write data over a valid/ready write-data channel.
- The RAM read path is combinational (data valid in the same cycle as read strobe + address). A RAM write commits at the posedge where the write strobe is high.

Parameters:
- ADDR_W, 16: address width of request and memory ports.
- DATA_W, 16: data word width.
- MEM_DEPTH, 256: RAM words; power of two; burst addresses wrap modulo MEM_DEPTH.
- LEN_W, 8: burst-length field width; beats = ReqLen+1.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ReqValid  in  1  request valid.
- ReqReady  out  1  request accepted when ReqValid & ReqReady.
- ReqWrite  in  1  1 = write burst, 0 = read burst.
- ReqAddr  in  ADDR_W  start word address.
- ReqLen  in  LEN_W  beats minus one.
- WDataValid  in  1  write beat valid.
- WDataReady  out  1  write beat accepted.
- WData  in  DATA_W  write beat data.
- RspValid  out  1  read data valid.
- RspReady  in  1  read data accepted.
- RspData  out  DATA_W  read data.
- RspLast  out  1  final beat of the read burst.
- Busy  out  1  high in any state other than IDLE.
- ReqErr  out  1  error pulse (MEM_BOUND_CHECK_EN only, else 0).
- MemAddress  out  ADDR_W  RAM address.
- MemRead  out  1  RAM read strobe.
- MemWrite  out  1  RAM write strobe.
- MemWData  out  DATA_W  RAM write data.
- MemRData  in  DATA_W  RAM read data (combinational from RAM).

Behaviour:
- Reset: every output 0 except ReqReady, which is 1 (IDLE). State = IDLE; address and beat counters = 0.
- Reset asserted mid-burst: abort immediately; remaining beats are discarded; RAM words already written are retained; no response for the aborted burst.
- States: IDLE, RD, RD_DRAIN, WR.
- IDLE:
  - ReqReady = 1.
  - On handshake: cur_addr <= ReqAddr mod MEM_DEPTH (upper bits dropped); remain <= ReqLen+1 (LEN_W+1 bits); go to WR if ReqWrite, else RD.
- RD:
  - Issue condition: !RspValid | RspReady.
  - Issue cycle: MemRead = 1, MemAddress = cur_addr. At the edge: RspData <= MemRData; RspValid <= 1; RspLast <= (remain==1); cur_addr <= (cur_addr+1) mod MEM_DEPTH; remain--.
  - Issuing the last beat moves the FSM to RD_DRAIN.
  - Non-issue cycle: MemRead = 0, MemAddress = 0. A RspReady handshake with no new issue clears RspValid.
- RD_DRAIN: MemRead = 0. When RspValid & RspReady: RspValid <= 0, RspLast <= 0, go to IDLE.
- Read latency: first RspValid 2 cycles after the request handshake edge. Sustained throughput is 1 beat/cycle with RspReady held high.
- RspData and RspLast hold stable while RspValid & !RspReady.
- WR:
  - WDataReady = 1.
  - When WDataValid: MemWrite = 1, MemAddress = cur_addr, MemWData = WData (combinational pass-through). At the edge: cur_addr++ (wrap), remain--.
  - After the last beat: go to IDLE; ReqReady is 1 on the next cycle.
  - WDataValid low: MemWrite = 0, MemAddress = 0, MemWData = 0.
  - First RAM write occurs 1 cycle after the request handshake.
- Invariants:
  - MemRead & MemWrite never both 1.
  - ReqReady = 0 outside IDLE.
  - WDataReady = 0 outside WR.
  - WData presented while not in WR is ignored.
- Wrap: address sequence from MEM_DEPTH-1 continues at 0.
- Max burst: ReqLen = 2^LEN_W-1 gives 256 beats.

Optional Feature:
- Macro: MEM_BOUND_CHECK_EN.
- Defined: a request with (ReqAddr mod MEM_DEPTH)+ReqLen+1 > MEM_DEPTH is still handshaken, but performs no RAM access and no response. ReqErr pulses 1 cycle on the cycle after the handshake; the FSM stays in IDLE.
- Not defined: ReqErr tied 0; crossing bursts wrap.

Test Plan:
- Single write: write ReqAddr=0x05, ReqLen=0, WData=0x1234 -> MemWrite=1 with MemAddress=0x05 one cycle after handshake. Then read 0x05 -> RspData=0x1234, RspLast=1, RspValid 2 cycles after handshake.
- Read burst with backpressure: preload RAM[0x10..0x13]=0xA0..0xA3; read ReqAddr=0x10, ReqLen=3, RspReady toggling 1,0,0,1,... -> RspData 0xA0..0xA3 in order, none dropped or duplicated, RspLast only on 0xA3, MemRead=0 during stalls.
- Wrap: write ReqAddr=0xFE, ReqLen=3, WData=1,2,3,4 with WDataValid gaps -> RAM[0xFE]=1, [0xFF]=2, [0x00]=3, [0x01]=4; MemWrite only on valid cycles. With MEM_BOUND_CHECK_EN defined -> ReqErr=1 for 1 cycle, no MemWrite.
- Reset mid-burst: drop RST_N during beat 2 of an 8-beat read -> all outputs 0 and ReqReady=1 asynchronously; a new request after release behaves normally.
- Back-to-back: write 0x20 len 0, then an immediate read 0x20 len 0 -> second ReqReady handshake occurs the cycle after the write beat; RspData equals the written value.
